mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/lane_align.sv | 37 +++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction with sign/zero extension, and lane merge for sub-word stores.
module lane_align #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  localparam int unsigned SHW = OFF_W + 3;

  logic [SHW-1:0]    shamt;
  int unsigned       nbits;
  logic [DATA_W-1:0] lmask;
  logic [DATA_W-1:0] fmask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    shamt   = {offset, 3'b000};
    nbits   = 32'd8 << size;
    lmask   = '1;
    if (nbits < DATA_W) lmask = ~({DATA_W{1'b1}} << nbits);
    shifted  = rdata >> shamt;
    // Full-width lanes never need extension; index is only meaningful below DATA_W.
    sign_bit = (nbits < DATA_W) ? shifted[SHW'(nbits - 32'd1)] : 1'b0;
    load_data = (shifted & lmask) | ((sign_ext && sign_bit) ? ~lmask : '0);
    fmask      = lmask << shamt;
    merge_data = (rdata & ~fmask) | ((wdata << shamt) & fmask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: alignment checking, sub-word read-modify-write, extended load results.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam size_t       FULL_SZ = (DATA_W == 64) ? SZ_DWORD : SZ_WORD;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  size_t             size_q;
  logic              signed_q;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] wdata_q;

  logic [OFF_W-1:0]  offset_c;
  logic [OFF_W-1:0]  amask_c;
  logic              err_c;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] merge_c;

  // Misaligned offset or a doubleword on a 32-bit bus is rejected up front.
  always_comb begin
    offset_c = req_addr[OFF_W-1:0];
    amask_c  = OFF_W'((32'd1 << req_size) - 32'd1);
    err_c    = 1'b0;
    if (req_size == SZ_DWORD && DATA_W == 32) err_c = 1'b1;
    else if ((offset_c & amask_c) != '0)      err_c = 1'b1;
  end

  lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_align (
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .offset     (off_q),
    .size       (size_q),
    .sign_ext   (signed_q),
    .load_data  (load_c),
    .merge_data (merge_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
    end else begin
      mem_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= size_t'(req_size);
            signed_q  <= req_signed;
            off_q     <= offset_c;
            wdata_q   <= req_wdata;
            if (err_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              if (req_we && req_size == FULL_SZ) begin
                state     <= WR;
                mem_wr    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state <= RD;
                cnt   <= '0;
              end
            end
          end
        end
        RD: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            if (we_q) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_wdata <= merge_c;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_c;
            end
          end
        end
        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, directed and random traffic.
module tb_mem_access_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT (words) and the reference view (bytes at 0x100..0x1FF).
  logic [31:0] wmem [0:63];
  logic [7:0]  bmem [0:255];
  assign mem_rdata = wmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr) wmem[mem_addr[7:2]] <= mem_wdata;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int unsigned at; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int unsigned at; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  // Monitor: every response and every memory write must match the head of its queue.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    if (!reset) begin
      if (rsp_valid) begin
        if (rq.size() == 0) flag("rsp_unexpected");
        else begin
          e = rq.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_cycle", 64'(cyc), 64'(e.at));
        end
      end else if (rq.size() != 0 && cyc > rq[0].at) begin
        flag("rsp_missing");
        void'(rq.pop_front());
      end
      if (mem_wr) begin
        if (wq.size() == 0) flag("wr_unexpected");
        else begin
          w = wq.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.addr));
          check("wr_data", 64'(mem_wdata), 64'(w.data));
          check("wr_cycle", 64'(cyc), 64'(w.at));
        end
      end else if (wq.size() != 0 && cyc > wq[0].at) begin
        flag("wr_missing");
        void'(wq.pop_front());
      end
    end
  end

  // Reference behaviour computed from byte-level memory semantics.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int unsigned t);
    int unsigned n;
    int unsigned base;
    logic [63:0] val;
    logic [31:0] word;
    rsp_t r;
    wr_t  w;
    n    = 32'd1 << sz;
    base = 32'(addr[7:0]);
    if (sz == 2'b11 || (addr % n) != 0) begin
      r = '{rdata: 32'h0, err: 1'b1, at: t + 1};
      rq.push_back(r);
    end else if (!we) begin
      val = '0;
      for (int i = 0; i < int'(n); i++) val = val | (64'(bmem[base + 32'(i)]) << (8 * i));
      if (sg && val[8 * n - 1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      r = '{rdata: val[31:0], err: 1'b0, at: t + LAT + 1};
      rq.push_back(r);
    end else begin
      for (int i = 0; i < int'(n); i++) bmem[base + 32'(i)] = wd[8 * i +: 8];
      base = base & 32'hFC;
      word = {bmem[base + 3], bmem[base + 2], bmem[base + 1], bmem[base]};
      w = '{addr: addr & 32'hFFFF_FFFC, data: word, at: (n == 4) ? t + 1 : t + LAT + 1};
      wq.push_back(w);
      r = '{rdata: 32'h0, err: 1'b0, at: (n == 4) ? t + 2 : t + LAT + 2};
      rq.push_back(r);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input bit abort,
                       output int unsigned t);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) flag("req_ready_timeout");
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    t = cyc;
    if (!abort) model(we, sz, sg, addr, wd, t);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (abort) begin
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_req_ready", 64'(req_ready), 64'd1);
      check("abort_mem_wr", 64'(mem_wr), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t1, t2, k;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      wmem[i] = $urandom;
      for (int b = 0; b < 4; b++) bmem[4 * i + b] = wmem[i][8 * b +: 8];
    end
    wmem[0] = 32'hAABBCCDD;
    bmem[0] = 8'hDD; bmem[1] = 8'hCC; bmem[2] = 8'hBB; bmem[3] = 8'hAA;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;

    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, t1);          // signed byte load
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, t1);          // unsigned half load
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, t1);          // word load
    issue(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 1'b0, t1);   // byte store RMW
    issue(1'b1, 2'b01, 1'b0, 32'h101, 32'hDEAD_BEEF, 1'b0, t1);  // misaligned half store
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, t1);          // misaligned word load
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b0, t1);          // doubleword on 32-bit bus
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h5A5A5A5A, 1'b1, t1);   // store aborted by reset
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, t1);          // memory untouched by abort
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hFFFFFFFF, 1'b0, t1);
    issue(1'b0, 2'b00, 1'b1, 32'h104, 32'h0, 1'b0, t2);
    check("b2b_accept_cycle", 64'(t2), 64'(t1 + 3));

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), 32'h100 + $urandom_range(0, 255),
            $urandom, 1'b0, t1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    k = 0;
    while ((rq.size() != 0 || wq.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);
    check("wr_queue_drained", 64'(wq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
